// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID consumer.
package if_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] PC_STEP   = 11'd4;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_HALT
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: '0};

  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load a fetched word, hold, or flush to a bubble.
module ifid_reg
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output ifid_t             ifid_o
);

  ifid_t ifid_q, ifid_d;

  // Flush wins over load; the PC field is meaningless in a bubble and is left as is.
  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (load_i) begin
      ifid_d.valid = 1'b1;
      ifid_d.instr = instr_i;
      ifid_d.pc    = pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q <= IFID_BUBBLE;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, boot/run/halt control and the IF/ID register.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 11'h000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              fault,
  output logic              halted
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word-aligned");
  end

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              ifid_load;
  logic              ifid_flush;
  ifid_t             ifid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      FS_BOOT: begin
        state_d = FS_RUN;
      end
      FS_RUN: begin
        if (halt_req) begin
          state_d    = FS_HALT;
          ifid_flush = 1'b1;
        end else if (redirect) begin
          ifid_flush = 1'b1;
          if (is_word_aligned(redirect_pc)) begin
            pc_d = redirect_pc;
          end else begin
            // Misaligned target: freeze rather than fetch from an illegal address.
            fault_d = 1'b1;
            state_d = FS_HALT;
          end
        end else if (!stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + PC_STEP;
        end
      end
      FS_HALT: begin
        ifid_flush = 1'b1;
      end
      default: begin
        state_d    = FS_HALT;
        ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (imem_rdata),
    .pc_i    (pc_q),
    .ifid_o  (ifid_q)
  );

  assign imem_addr  = pc_q;
  assign ifid_valid = ifid_q.valid;
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc    = ifid_q.pc;
  assign fault      = fault_q;
  assign halted     = (state_q == FS_HALT);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage with a word-addressed memory model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [10:0] redirect_pc;
  logic        halt_req;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [10:0] ifid_pc;
  logic        fault;
  logic        halted;

  logic [31:0] mem [512];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [10:0] rpc;
    logic        halt;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [10:0] e_pc;
    logic        chk_pc;
    logic [10:0] e_addr;
    logic        e_fault;
    logic        e_halted;
  } vec_t;

  vec_t vq[$];

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .fault       (fault),
    .halted      (halted)
  );

  assign imem_rdata = mem[imem_addr[10:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 11'h000;
    halt_req    = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'd0);
    chk({tag, ".instr"}, ifid_instr, 32'h0000_0013);
    chk({tag, ".pc"}, 32'(ifid_pc), 32'd0);
    chk({tag, ".addr"}, 32'(imem_addr), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".halted"}, 32'(halted), 32'd0);
  endtask

  task automatic add(input logic st, input logic rd, input logic [10:0] rpc, input logic hr,
                     input logic ev, input logic [31:0] ei, input logic [10:0] ep,
                     input logic cp, input logic [10:0] ea, input logic ef, input logic eh);
    vec_t v;
    v.stall = st; v.redirect = rd; v.rpc = rpc; v.halt = hr;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.chk_pc = cp;
    v.e_addr = ea; v.e_fault = ef; v.e_halted = eh;
    vq.push_back(v);
  endtask

  // Assert rst just after an edge, check, then release just after the following edge.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_values(tag);
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | (i * 4);
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;

    idle_inputs();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_values("rst0");
    step();
    step();
    rst = 1'b0;

    //  st rd rpc     hr  ev  instr          pc      cp  addr    f  h
    add(0, 0, 11'h0,   0,  0, 32'h0000_0013, 11'h0,   1, 11'h000, 0, 0); // boot edge
    add(0, 0, 11'h0,   0,  1, 32'h1111_1111, 11'h0,   1, 11'h004, 0, 0);
    add(0, 0, 11'h0,   0,  1, 32'h2222_2222, 11'h4,   1, 11'h008, 0, 0);
    add(1, 0, 11'h0,   0,  1, 32'h2222_2222, 11'h4,   1, 11'h008, 0, 0);
    add(1, 0, 11'h0,   0,  1, 32'h2222_2222, 11'h4,   1, 11'h008, 0, 0);
    add(1, 0, 11'h0,   0,  1, 32'h2222_2222, 11'h4,   1, 11'h008, 0, 0);
    add(0, 0, 11'h0,   0,  1, 32'h3333_3333, 11'h8,   1, 11'h00C, 0, 0);
    add(1, 1, 11'h100, 0,  0, 32'h0000_0013, 11'h0,   0, 11'h100, 0, 0); // redirect beats stall
    add(0, 0, 11'h0,   0,  1, 32'hA000_0100, 11'h100, 1, 11'h104, 0, 0);
    add(0, 1, 11'h7FC, 0,  0, 32'h0000_0013, 11'h0,   0, 11'h7FC, 0, 0);
    add(0, 0, 11'h0,   0,  1, 32'hA000_07FC, 11'h7FC, 1, 11'h000, 0, 0); // wrap
    add(0, 0, 11'h0,   0,  1, 32'h1111_1111, 11'h0,   1, 11'h004, 0, 0);
    add(0, 1, 11'h102, 0,  0, 32'h0000_0013, 11'h0,   0, 11'h004, 1, 1); // misaligned
    add(0, 1, 11'h200, 1,  0, 32'h0000_0013, 11'h0,   0, 11'h004, 1, 1); // ignored in halt
    add(1, 0, 11'h0,   0,  0, 32'h0000_0013, 11'h0,   0, 11'h004, 1, 1);
    add(0, 0, 11'h0,   0,  0, 32'h0000_0013, 11'h0,   0, 11'h004, 1, 1);

    foreach (vq[i]) begin
      stall       = vq[i].stall;
      redirect    = vq[i].redirect;
      redirect_pc = vq[i].rpc;
      halt_req    = vq[i].halt;
      step();
      chk($sformatf("v%0d.valid", i), 32'(ifid_valid), 32'(vq[i].e_valid));
      chk($sformatf("v%0d.instr", i), ifid_instr, vq[i].e_instr);
      if (vq[i].chk_pc) chk($sformatf("v%0d.pc", i), 32'(ifid_pc), 32'(vq[i].e_pc));
      chk($sformatf("v%0d.addr", i), 32'(imem_addr), 32'(vq[i].e_addr));
      chk($sformatf("v%0d.fault", i), 32'(fault), 32'(vq[i].e_fault));
      chk($sformatf("v%0d.halted", i), 32'(halted), 32'(vq[i].e_halted));
    end
    idle_inputs();

    // Reset clears the sticky fault and halt.
    reset_pulse("rst1");
    step();
    chk("boot2.valid", 32'(ifid_valid), 32'd0);
    chk("boot2.addr", 32'(imem_addr), 32'h000);
    step();
    chk("run2.instr", ifid_instr, 32'h1111_1111);
    chk("run2.addr", 32'(imem_addr), 32'h004);

    // halt_req outranks a simultaneous redirect.
    halt_req    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 11'h040;
    step();
    idle_inputs();
    chk("hr.halted", 32'(halted), 32'd1);
    chk("hr.fault", 32'(fault), 32'd0);
    chk("hr.addr", 32'(imem_addr), 32'h004);
    chk("hr.valid", 32'(ifid_valid), 32'd0);
    step();
    chk("hr2.addr", 32'(imem_addr), 32'h004);
    chk("hr2.halted", 32'(halted), 32'd1);

    // Async reset mid-cycle while running with a valid IF/ID entry.
    reset_pulse("rst2");
    step();
    step();
    step();
    chk("pre.valid", 32'(ifid_valid), 32'd1);
    chk("pre.pc", 32'(ifid_pc), 32'h004);
    chk("pre.addr", 32'(imem_addr), 32'h008);
    #2 rst = 1'b1;
    #1 chk_reset_values("rst3");
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipeline. It owns the program counter, drives the word-aligned byte address into the 2 KB instruction memory, and captures the returned 32-bit word with its PC into the IF/ID pipeline register. It handles stall, branch/jump redirect (flush), halt and a misaligned-target fault.

Parameters:
ADDR_W, 11, byte-address width; 2 KB instruction space.
DATA_W, 32, instruction width.
RESET_PC, 11'h000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble instruction placed in IF/ID when invalid.

Ports:
clk  in  1  single pipeline clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_addr  out  ADDR_W  byte address to instruction memory; equals PC, combinational.
imem_rdata  in  DATA_W  instruction word from memory, combinational read, same cycle.
stall  in  1  hazard unit: hold PC and IF/ID.
redirect  in  1  EX stage: taken branch/jump, flush IF/ID.
redirect_pc  in  ADDR_W  new PC when redirect=1.
halt_req  in  1  stop fetching; sticky until reset.
ifid_valid  out  1  IF/ID holds a real instruction.
ifid_instr  out  DATA_W  captured instruction, NOP_INSTR when invalid.
ifid_pc  out  ADDR_W  PC of captured instruction.
fault  out  1  misaligned redirect target seen; sticky.
halted  out  1  FSM in FS_HALT.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): pc=RESET_PC, state=FS_BOOT, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, fault=0, halted=0.
- imem_addr = pc at all times, including FS_HALT.
- FSM states: FS_BOOT, FS_RUN, FS_HALT.
- FS_BOOT: lasts exactly one cycle after rst deasserts. No capture and no PC change. Transitions to FS_RUN unconditionally, ignoring all inputs.
- FS_RUN uses priority halt_req > redirect > stall > advance. Each rule is evaluated per rising edge:
  - halt_req=1: state -> FS_HALT; ifid_valid<=0; ifid_instr<=NOP_INSTR; pc held.
  - redirect=1 with redirect_pc[1:0]==0: pc<=redirect_pc; ifid_valid<=0; ifid_instr<=NOP_INSTR. Applies even if stall=1.
  - redirect=1 with redirect_pc[1:0]!=0: fault<=1; state -> FS_HALT; pc held; ifid invalidated.
  - stall=1: pc, ifid_valid, ifid_instr and ifid_pc all hold.
  - Otherwise (advance): ifid_instr<=imem_rdata; ifid_pc<=pc; ifid_valid<=1; pc<=pc+4.
- PC arithmetic is modulo 2^ADDR_W. pc=11'h7FC advances to 11'h000 with no flag.
- Fetch-to-IF/ID latency is 1 cycle. Once in FS_RUN, the first valid instruction appears on the edge after the FS_BOOT cycle.
- FS_HALT: absorbing state, left only by rst. PC frozen; ifid_valid=0; stall, redirect and halt_req ignored.
- halted=1 iff state==FS_HALT. fault stays 1 until rst.
- Bits [1:0] of pc are always 0 (RESET_PC must be word-aligned; checked with an elaboration assertion).

Decomposition:
- Package if_pkg holds ADDR_W, DATA_W, NOP_INSTR, the enum fetch_state_t {FS_BOOT, FS_RUN, FS_HALT}, and the struct ifid_t {valid, instr, pc} shared with the decode stage.
- One sub-module, ifid_reg: IF/ID register with load, hold and flush controls; reset to the bubble value.
- PC register and FSM live in the top module.

Test Plan:
- Reset then free-run, memory words 0x11111111 @0, 0x22222222 @4, 0x33333333 @8 -> one bubble cycle, then ifid_instr=0x11111111 (pc 0), 0x22222222 (pc 4), 0x33333333 (pc 8) on consecutive edges, ifid_valid=1.
- Assert stall for 3 cycles while ifid_pc=4 -> ifid_pc=4, ifid_instr=0x22222222, imem_addr=8 held for all 3 cycles; resumes with pc 8.
- redirect=1, redirect_pc=0x100 together with stall=1 -> next edge ifid_valid=0, ifid_instr=0x00000013, imem_addr=0x100; next edge captures word @0x100 with ifid_pc=0x100.
- Start from pc=0x7FC in free-run -> ifid_pc=0x7FC, then imem_addr wraps to 0x000, fault=0.
- redirect with redirect_pc=0x102 -> fault=1, halted=1, ifid_valid=0, imem_addr frozen. Later redirect and halt_req are ignored; rst pulse clears fault and returns pc to 0.
- halt_req and redirect asserted in the same cycle -> halted=1, pc unchanged (redirect dropped). Async rst asserted mid-cycle -> all outputs reach reset values before the next clk edge.
